// File: rtl/ccff_shadow_cfg.sv
// ccff_shadow_cfg: serial config chain cell with parity/length-checked, handshaked shadow commit
module ccff_shadow_cfg #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic             ccff_head,
  input  logic             shift_en,
  input  logic             commit_req,
  output logic             ccff_tail,
  output logic             commit_ack,
  output logic [WIDTH-1:0] sram,
  output logic [WIDTH-1:0] sram_inv,
  output logic             cfg_valid,
  output logic             parity_err,
  output logic             frame_err
);
  localparam int N  = WIDTH + PARITY_EN;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CHECK, ACK} state_t;
  state_t           r_state, w_next;
  logic [N-1:0]     r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shadow, w_data;
  logic             r_cfg_valid, r_parity_err, r_frame_err;
  logic [N:0]       w_sr_ext;
  logic             w_shift, w_full, w_par_ok;
  assign w_sr_ext = {r_sr, ccff_head};
  assign w_shift  = (r_state == IDLE) && shift_en;
  assign w_full   = r_cnt == CW'(N);
  assign w_par_ok = (PARITY_EN == 0) || !(^r_sr);
  always_comb begin
    w_data = '0;
    for (int i = 0; i < WIDTH; i++) w_data[i] = r_sr[N-1-i];
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && commit_req && !shift_en) w_next = CHECK;
    else if (r_state == CHECK) w_next = ACK;
    else if (r_state == ACK && !commit_req) w_next = IDLE;
  end
  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_cfg_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_shift) begin
        r_sr <= w_sr_ext[N-1:0];
        if (!w_full) r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == CHECK) begin
        r_cnt <= '0;
        if (!w_full) r_frame_err <= 1'b1;
        else if (w_par_ok) begin
          r_shadow     <= w_data;
          r_cfg_valid  <= 1'b1;
          r_parity_err <= 1'b0;
          r_frame_err  <= 1'b0;
        end else begin
          r_parity_err <= 1'b1;
          r_frame_err  <= 1'b0;
        end
      end
    end
  end
  assign ccff_tail  = r_sr[N-1];
  assign commit_ack = r_state == ACK;
  assign sram       = r_shadow;
  assign sram_inv   = ~r_shadow;
  assign cfg_valid  = r_cfg_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
endmodule
